// File: rtl/adder_display_pkg.sv
// Shared types and constants for the BCD adder / scanned 7-segment display.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package adder_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

    function automatic logic [63:0] max_bcd(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/adder_bcd_scan_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern; codes 10..15 render blank.
module seg7_decode
    import adder_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_DIGIT[0];
            4'd1: seg = SEG_DIGIT[1];
            4'd2: seg = SEG_DIGIT[2];
            4'd3: seg = SEG_DIGIT[3];
            4'd4: seg = SEG_DIGIT[4];
            4'd5: seg = SEG_DIGIT[5];
            4'd6: seg = SEG_DIGIT[6];
            4'd7: seg = SEG_DIGIT[7];
            4'd8: seg = SEG_DIGIT[8];
            4'd9: seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adder_bcd_scan_display.sv
// Adder with sequential double-dabble and anode-scanned 7-segment output.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module adder_bcd_scan_display
    import adder_display_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [WIDTH:0]    sum,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int SW = WIDTH + 1;
    localparam int BW = 4 * DIGITS;
    localparam int IW = $clog2(WIDTH + 2);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int XW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] MAX_VAL = max_bcd(DIGITS);

    state_e            state_q, state_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [BW-1:0]     digit_q, digit_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [BW-1:0]     adj;
    logic              msb;
    logic [3:0]        cur_digit;
    logic [6:0]        dec_seg;
    logic              blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            digit_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= ~DIGITS'(1);
            seg_q   <= SEG_DIGIT[0];
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            digit_q <= digit_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    // One double-dabble step: add-3 correction, then shift in next sum bit
    always_comb begin
        msb = 1'b0;
        for (int i = 0; i < SW; i++) begin
            if (int'(iter_q) == WIDTH - i) begin
                msb = sum_q[i];
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        digit_d = digit_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    sum_d   = SW'(a) + SW'(b) + SW'(cin);
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d  = (adj << 1) | BW'(msb);
                iter_d = iter_q + 1'b1;
                if (iter_q == IW'(WIDTH)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digit_d = bcd_q;
                ovf_d   = (64'(sum_q) > MAX_VAL);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == XW'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Decode from next-cycle digit/index so an and seg move on one edge
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(idx_d) == i) begin
                cur_digit = digit_d[4*i +: 4];
            end
        end
    end

    seg7_decode u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;
    always_comb begin
        zero_above = 1'b1;
        blank      = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (digit_d[4*i +: 4] == 4'd0);
            if (zero_above && int'(idx_d) == i) begin
                blank = 1'b1;
            end
        end
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_comb begin
        an_d = ~(DIGITS'(1) << idx_d);
        if (ovf_d) begin
            seg_d = SEG_DASH;
        end else if (blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = dec_seg;
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        ovf  = ovf_q;
        sum  = sum_q;
        an   = an_q;
        seg  = seg_q;
    end

endmodule

// File: tb/tb_adder_bcd_scan_display.sv
// Directed bench: 4-digit and 2-digit instances, REFRESH_DIV=4.
// Expected leading-zero rendering follows LEADING_ZERO_BLANK_EN.
module tb_adder_bcd_scan_display;

    logic       clk;
    logic       rst;
    logic       load0, load1;
    logic [7:0] a0, b0, a1, b1;
    logic       cin0, cin1;
    logic       busy0, done0, ovf0;
    logic       busy1, done1, ovf1;
    logic [8:0] sum0, sum1;
    logic [3:0] an0;
    logic [1:0] an1;
    logic [6:0] seg0, seg1;

    int vectors;
    int miscompares;
    logic [6:0] lz;

    adder_bcd_scan_display #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .load(load0), .a(a0), .b(b0), .cin(cin0),
        .busy(busy0), .done(done0), .ovf(ovf0), .sum(sum0),
        .an(an0), .seg(seg0)
    );

    adder_bcd_scan_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .ovf(ovf1), .sum(sum1),
        .an(an1), .seg(seg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic read0(input int k, output logic [6:0] s, output bit ok);
        logic [3:0] want_an;
        want_an = 4'b0001 << k;
        want_an = ~want_an;
        ok = 1'b0;
        s  = 7'bx;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (an0 === want_an) begin
                s  = seg0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read1(input int k, output logic [6:0] s, output bit ok);
        logic [1:0] want_an;
        want_an = 2'b01 << k;
        want_an = ~want_an;
        ok = 1'b0;
        s  = 7'bx;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (an1 === want_an) begin
                s  = seg1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] e_an0;
        logic [1:0] e_an1;
        logic [6:0] e_seg;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || ovf0 !== 1'b0 || sum0 !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl got busy=%b done=%b ovf=%b sum=%0d want 0 0 0 0",
                     busy0, done0, ovf0, sum0);
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            e_an0 = 4'b0001 << (k / 4);
            e_an0 = ~e_an0;
            e_an1 = 2'b01 << ((k / 4) % 2);
            e_an1 = ~e_an1;
            e_seg = ((k / 4) == 0) ? 7'b1000000 : lz;
            vectors++;
            if (an0 !== e_an0 || seg0 !== e_seg || an1 !== e_an1) begin
                miscompares++;
                $display("FAIL reset_scan k=%0d got an0=%b seg0=%b an1=%b want %b %b %b",
                         k, an0, seg0, an1, e_an0, e_seg, e_an1);
            end
        end
    endtask

    task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int first, output int pulses);
        a0 = a; b0 = b; cin0 = c; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        first = 0; pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int first, output int pulses);
        a1 = a; b1 = b; cin1 = c; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        first = 0; pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic test_add_256();
        int first, pulses;
        logic [6:0] s;
        logic [6:0] want [4];
        bit ok;
        want = '{7'b0000010, 7'b0010010, 7'b0100100, lz};
        a0 = 8'd200; b0 = 8'd55; cin0 = 1'b1; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        vectors++;
        if (busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL add256_busy got %b want 1", busy0);
        end
        first = 0; pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        vectors++;
        if (first != 10 || pulses != 1) begin
            miscompares++;
            $display("FAIL add256_latency got cycle=%0d pulses=%0d want 10 1", first, pulses);
        end
        vectors++;
        if (sum0 !== 9'd256 || ovf0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL add256_result got sum=%0d ovf=%b busy=%b want 256 0 0",
                     sum0, ovf0, busy0);
        end
        for (int d = 0; d < 4; d++) begin
            read0(d, s, ok);
            vectors++;
            if (!ok || s !== want[d]) begin
                miscompares++;
                $display("FAIL add256_digit%0d got %b want %b", d, s, want[d]);
            end
        end
    endtask

    task automatic test_ignored_load();
        int first, pulses;
        logic [6:0] s;
        logic [6:0] want [4];
        bit ok;
        want = '{7'b0110000, 7'b0100100, 7'b1111001, lz};
        a0 = 8'd100; b0 = 8'd23; cin0 = 1'b0; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        first = 0; pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) begin
                a0 = 8'd1; b0 = 8'd1; cin0 = 1'b1; load0 = 1'b1;
            end
            @(negedge clk);
            load0 = 1'b0;
            if (done0 === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        vectors++;
        if (first != 10 || pulses != 1) begin
            miscompares++;
            $display("FAIL ignored_done got cycle=%0d pulses=%0d want 10 1", first, pulses);
        end
        vectors++;
        if (sum0 !== 9'd123 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_sum got sum=%0d busy=%b want 123 0", sum0, busy0);
        end
        for (int d = 0; d < 4; d++) begin
            read0(d, s, ok);
            vectors++;
            if (!ok || s !== want[d]) begin
                miscompares++;
                $display("FAIL ignored_digit%0d got %b want %b", d, s, want[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dcount, bcount;
        logic [3:0] an_at3, an_at4;
        logic [6:0] s;
        bit ok;
        a0 = 8'd9; b0 = 8'd9; cin0 = 1'b0; load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy0 !== 1'b0 || sum0 !== 9'd0 || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state got busy=%b sum=%0d ovf0=%b ovf1=%b want 0 0 0 0",
                     busy0, sum0, ovf0, ovf1);
        end
        vectors++;
        if (an0 !== 4'b1110 || seg0 !== 7'b1000000 || an1 !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst_display got an0=%b seg0=%b an1=%b want 1110 1000000 10",
                     an0, seg0, an1);
        end
        dcount = 0; bcount = 0; an_at3 = 'x; an_at4 = 'x;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) dcount++;
            if (busy0 === 1'b1) bcount++;
            if (k == 3) an_at3 = an0;
            if (k == 4) an_at4 = an0;
        end
        vectors++;
        if (dcount != 0 || bcount != 0) begin
            miscompares++;
            $display("FAIL midrst_quiet got done=%0d busy=%0d want 0 0", dcount, bcount);
        end
        vectors++;
        if (an_at3 !== 4'b1110 || an_at4 !== 4'b1101) begin
            miscompares++;
            $display("FAIL midrst_scan got %b %b want 1110 1101", an_at3, an_at4);
        end
        read0(2, s, ok);
        vectors++;
        if (!ok || s !== lz) begin
            miscompares++;
            $display("FAIL midrst_digit2 got %b want %b", s, lz);
        end
    endtask

    task automatic test_max_sum();
        int first, pulses;
        logic [6:0] s;
        logic [6:0] want [4];
        bit ok;
        want = '{7'b1111001, 7'b1111001, 7'b0010010, lz};
        run0(8'd255, 8'd255, 1'b1, first, pulses);
        vectors++;
        if (first != 10 || pulses != 1 || sum0 !== 9'd511 || ovf0 !== 1'b0) begin
            miscompares++;
            $display("FAIL max_result got cycle=%0d pulses=%0d sum=%0d ovf=%b want 10 1 511 0",
                     first, pulses, sum0, ovf0);
        end
        for (int d = 0; d < 4; d++) begin
            read0(d, s, ok);
            vectors++;
            if (!ok || s !== want[d]) begin
                miscompares++;
                $display("FAIL max_digit%0d got %b want %b", d, s, want[d]);
            end
        end
    endtask

    task automatic test_seven();
        int first, pulses;
        logic [6:0] s;
        logic [6:0] want [4];
        bit ok;
        want = '{7'b1111000, lz, lz, lz};
        run0(8'd7, 8'd0, 1'b0, first, pulses);
        vectors++;
        if (first != 10 || sum0 !== 9'd7) begin
            miscompares++;
            $display("FAIL seven_result got cycle=%0d sum=%0d want 10 7", first, sum0);
        end
        for (int d = 0; d < 4; d++) begin
            read0(d, s, ok);
            vectors++;
            if (!ok || s !== want[d]) begin
                miscompares++;
                $display("FAIL seven_digit%0d got %b want %b", d, s, want[d]);
            end
        end
    endtask

    task automatic test_overflow();
        int first, pulses;
        logic [6:0] s;
        bit ok;
        run1(8'd60, 8'd45, 1'b0, first, pulses);
        vectors++;
        if (first != 10 || pulses != 1 || sum1 !== 9'd105 || ovf1 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_result got cycle=%0d pulses=%0d sum=%0d ovf=%b want 10 1 105 1",
                     first, pulses, sum1, ovf1);
        end
        for (int d = 0; d < 2; d++) begin
            read1(d, s, ok);
            vectors++;
            if (!ok || s !== 7'b0111111) begin
                miscompares++;
                $display("FAIL ovf_digit%0d got %b want 0111111", d, s);
            end
        end
        run1(8'd99, 8'd0, 1'b0, first, pulses);
        vectors++;
        if (sum1 !== 9'd99 || ovf1 !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf99_result got sum=%0d ovf=%b want 99 0", sum1, ovf1);
        end
        for (int d = 0; d < 2; d++) begin
            read1(d, s, ok);
            vectors++;
            if (!ok || s !== 7'b0010000) begin
                miscompares++;
                $display("FAIL ovf99_digit%0d got %b want 0010000", d, s);
            end
        end
        run1(8'd99, 8'd0, 1'b1, first, pulses);
        vectors++;
        if (sum1 !== 9'd100 || ovf1 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf100_result got sum=%0d ovf=%b want 100 1", sum1, ovf1);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
`ifdef LEADING_ZERO_BLANK_EN
        lz = 7'b1111111;
`else
        lz = 7'b1000000;
`endif
        rst = 1'b1;
        load0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
        load1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_add_256();
        test_ignored_load();
        test_reset_mid();
        test_max_sum();
        test_seven();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
